// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - ready/valid pipeline stage with flush and saturating stall counter.
// Define PIPE_STAGE_REG_SKID_EN for the two-entry skid build with registered in_ready.
module pipe_stage_reg #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] NOP_VALUE   = {WIDTH{1'b0}},
   parameter int unsigned      STALL_CNT_W = 16
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   input  logic                   flush,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

   localparam logic [STALL_CNT_W-1:0] STALL_ONE = 1;

   state_e                   state_q, state_d;
   logic [WIDTH-1:0]         main_q, main_d;
   logic [STALL_CNT_W-1:0]   stall_q, stall_d;
   logic                     accept, take;

   assign out_valid   = (state_q != EMPTY);
   assign out_data    = main_q;
   assign accept      = in_valid & in_ready;
   assign take        = out_valid & out_ready;
   assign stall_count = stall_q;

   always_comb begin
      stall_d = stall_q;
      if (out_valid && !out_ready && (stall_q != '1)) begin
         stall_d = stall_q + STALL_ONE;
      end
   end

`ifdef PIPE_STAGE_REG_SKID_EN
   logic [WIDTH-1:0] skid_q, skid_d;

   // in_ready depends only on state, so out_ready never reaches it combinationally
   assign in_ready  = (state_q != TWO);
   assign occupancy = (state_q == TWO) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               main_d  = in_data;
            end
         end
         ONE: begin
            if (accept && take) begin
               main_d = in_data;
            end else if (accept) begin
               state_d = TWO;
               skid_d  = in_data;
            end else if (take) begin
               state_d = EMPTY;
               main_d  = NOP_VALUE;
            end
         end
         TWO: begin
            if (take) begin
               state_d = ONE;
               main_d  = skid_q;
               skid_d  = NOP_VALUE;
            end
         end
         default: begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
         end
      endcase
      if (flush) begin
         state_d = EMPTY;
         main_d  = NOP_VALUE;
         skid_d  = NOP_VALUE;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         skid_q <= NOP_VALUE;
      end else begin
         skid_q <= skid_d;
      end
   end
`else
   assign in_ready  = out_ready | ~out_valid;
   assign occupancy = {1'b0, (state_q == ONE)};

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (accept) begin
         state_d = ONE;
         main_d  = in_data;
      end else if (take) begin
         state_d = EMPTY;
         main_d  = NOP_VALUE;
      end
      if (flush) begin
         state_d = EMPTY;
         main_d  = NOP_VALUE;
      end
   end
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= EMPTY;
         main_q  <= NOP_VALUE;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         stall_q <= stall_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg against a FIFO reference model.
module tb_pipe_stage_reg;

   localparam int unsigned W   = 16;
   localparam int unsigned SW  = 3;
   localparam logic [W-1:0] NOP = 16'hDEAD;
   localparam int STALL_MAX = (1 << SW) - 1;
`ifdef PIPE_STAGE_REG_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          in_valid, in_ready, out_valid, out_ready, flush;
   logic [W-1:0]  in_data, out_data;
   logic [1:0]    occupancy;
   logic [SW-1:0] stall_count;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [W-1:0] model_q[$];
   int           stall_m = 0;
   bit           exp_rdy, acc, tk;
   logic [W-1:0] popped;

   pipe_stage_reg #(.WIDTH(W), .NOP_VALUE(NOP), .STALL_CNT_W(SW)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .flush(flush), .occupancy(occupancy), .stall_count(stall_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: the stage is a FIFO of depth CAP; flush empties it and drops the same-cycle input.
   always @(negedge CLK) begin
      if (!RST_N) begin
         model_q.delete();
         stall_m = 0;
      end else begin
         exp_rdy = (CAP == 2) ? (model_q.size() < 2) : (out_ready || model_q.size() == 0);
         check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
         check("out_valid", {31'b0, out_valid}, {31'b0, model_q.size() != 0});
         check("occupancy", {30'b0, occupancy}, model_q.size());
         check("stall_count", {29'b0, stall_count}, stall_m);
         if (model_q.size() != 0) check("out_data", {16'b0, out_data}, {16'b0, model_q[0]});
         else check("bubble_data", {16'b0, out_data}, {16'b0, NOP});
         acc = in_valid && exp_rdy;
         tk  = (model_q.size() != 0) && out_ready;
         if (model_q.size() != 0 && !out_ready && stall_m < STALL_MAX) stall_m++;
         if (flush) model_q.delete();
         else begin
            if (tk) popped = model_q.pop_front();
            if (acc) model_q.push_back(in_data);
         end
      end
   end

   task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
      in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
      @(posedge CLK); #1;
   endtask

   initial begin
      in_valid = 0; in_data = '0; out_ready = 0; flush = 0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 0);
      check("rst_out_data", {16'b0, out_data}, {16'b0, NOP});
      check("rst_in_ready", {31'b0, in_ready}, 1);
      check("rst_occupancy", {30'b0, occupancy}, 0);
      check("rst_stall", {29'b0, stall_count}, 0);
      RST_N = 1;

      for (int i = 1; i <= 8; i++) cycle(1, W'(i), 1, 0);
      cycle(0, '0, 1, 0);
      cycle(0, '0, 1, 0);
      check("stream_stall_zero", {29'b0, stall_count}, 0);

      cycle(1, 16'h0055, 0, 0);
      repeat (10) cycle(0, '0, 0, 0);
      check("stall_saturated", {29'b0, stall_count}, 7);
`ifndef PIPE_STAGE_REG_SKID_EN
      out_ready = 0; #1;
      check("comb_ready_low", {31'b0, in_ready}, 0);
      out_ready = 1; #1;
      check("comb_ready_high", {31'b0, in_ready}, 1);
      check("nonskid_occ_max", {31'b0, occupancy <= 2'd1}, 1);
`endif
      cycle(0, '0, 1, 0);
      cycle(0, '0, 1, 0);

      cycle(1, 16'h000A, 1, 0);
      cycle(1, 16'h000B, 0, 0);
      cycle(1, 16'h000C, 0, 0);
`ifdef PIPE_STAGE_REG_SKID_EN
      check("bp_occupancy", {30'b0, occupancy}, 2);
      check("bp_in_ready", {31'b0, in_ready}, 0);
`endif
      cycle(1, 16'h000C, 1, 0);
      cycle(1, 16'h000C, 1, 0);
      cycle(0, '0, 1, 0);
      cycle(0, '0, 1, 0);

      cycle(1, 16'h0011, 1, 0);
      cycle(1, 16'h0022, 0, 0);
      cycle(1, 16'h00DD, 0, 1);
      check("flush_valid", {31'b0, out_valid}, 0);
      check("flush_data", {16'b0, out_data}, {16'b0, NOP});
      check("flush_occ", {30'b0, occupancy}, 0);
      cycle(0, '0, 1, 0);
      cycle(0, '0, 1, 0);

      for (int i = 0; i < 300; i++)
         cycle(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 9) < 7),
               1'($urandom_range(0, 29) == 0));

      cycle(1, 16'h0101, 1, 0);
      cycle(1, 16'h0202, 0, 0);
      cycle(1, 16'h0303, 0, 0);
      #2 RST_N = 0;
      #1;
      check("mid_rst_valid", {31'b0, out_valid}, 0);
      check("mid_rst_data", {16'b0, out_data}, {16'b0, NOP});
      check("mid_rst_occ", {30'b0, occupancy}, 0);
      check("mid_rst_stall", {29'b0, stall_count}, 0);
      check("mid_rst_ready", {31'b0, in_ready}, 1);
      @(posedge CLK); #1;
      RST_N = 1;
      cycle(1, 16'h0404, 1, 0);
      cycle(0, '0, 1, 0);
      cycle(0, '0, 1, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
